// File: rtl/pc_sel_ctrl_pkg.sv
// Shared next-PC select encodings and BHT counter helpers for the fetch sequencer
// and the next-PC mux.
package pc_sel_ctrl_pkg;

    localparam logic [2:0] NPC_SEQ    = 3'b000;
    localparam logic [2:0] NPC_BR_IF  = 3'b001;
    localparam logic [2:0] NPC_REC_ID = 3'b010;
    localparam logic [2:0] NPC_J_ID   = 3'b011;
    localparam logic [2:0] NPC_JR     = 3'b100;

    localparam logic [1:0] BHT_INIT = 2'b01;

    // Saturating 2-bit counter step: taken counts up to 3, not-taken down to 0.
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] r;
        r = ctr;
        if (taken && ctr != 2'b11) begin
            r = ctr + 2'b01;
        end else if (!taken && ctr != 2'b00) begin
            r = ctr - 2'b01;
        end
        return r;
    endfunction

endpackage

// File: rtl/pc_sel_ctrl_if.sv
// Bundle of pipeline-side signals between the fetch/decode stages and the
// next-PC sequencing controller.
interface pc_sel_ctrl_if;

    logic        stall;
    logic [31:0] next_pc;
    logic        branch_IF;
    logic        branch_ID;
    logic        taken_ID;
    logic        jump_ID;
    logic        jr_ID;
    logic [2:0]  next_pc_sel;
    logic [31:0] pc;
    logic        flush_IF;
    logic        mispredict;
    logic [31:0] br_cnt;
    logic [31:0] mp_cnt;

    modport master (
        output stall, next_pc, branch_IF, branch_ID, taken_ID, jump_ID, jr_ID,
        input  next_pc_sel, pc, flush_IF, mispredict, br_cnt, mp_cnt
    );

    modport slave (
        input  stall, next_pc, branch_IF, branch_ID, taken_ID, jump_ID, jr_ID,
        output next_pc_sel, pc, flush_IF, mispredict, br_cnt, mp_cnt
    );

endinterface

// File: rtl/pc_sel_ctrl_bht_2bit.sv
// Branch history table of 2-bit saturating counters: asynchronous read port,
// synchronous update port, no read-during-write bypass.
module bht_2bit
    import pc_sel_ctrl_pkg::*;
#(
    parameter int unsigned IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [1:0]       o_rdata,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic             i_taken
);

    localparam int unsigned Entries = 2 ** IDX_W;

    logic [1:0] r_ctr [Entries];

    assign o_rdata = r_ctr[i_raddr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Entries; i++) begin
                r_ctr[i] <= BHT_INIT;
            end
        end else if (i_we) begin
            r_ctr[i_waddr] <= sat_update(r_ctr[i_waddr], i_taken);
        end
    end

endmodule

// File: rtl/pc_sel_ctrl.sv
// Next-PC sequencing controller: holds the fetch PC, predicts IF branches from
// the BHT, and selects ID-stage redirects with the matching IF flush.
module pc_sel_ctrl
    import pc_sel_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter int unsigned BHT_IDX_W = 6
) (
    input logic          clk,
    input logic          rst,
    pc_sel_ctrl_if.slave bus
);

    logic [31:0]          r_pc;
    logic                 r_pred_ID;
    logic [BHT_IDX_W-1:0] r_idx_ID;
    logic [31:0]          r_br_cnt;
    logic [31:0]          r_mp_cnt;

    logic [BHT_IDX_W-1:0] w_idx;
    logic [1:0]           w_ctr;
    logic                 w_pred_IF;
    logic                 w_jr;
    logic                 w_jump;
    logic                 w_mispredict;
    logic                 w_redirect;
    logic                 w_resolve;
    logic [2:0]           w_sel;

    assign w_idx = r_pc[BHT_IDX_W+1:2];

    bht_2bit #(
        .IDX_W (BHT_IDX_W)
    ) u_bht (
        .clk     (clk),
        .rst     (rst),
        .i_raddr (w_idx),
        .o_rdata (w_ctr),
        .i_we    (w_resolve),
        .i_waddr (r_idx_ID),
        .i_taken (bus.taken_ID)
    );

    assign w_pred_IF    = bus.branch_IF & w_ctr[1];
    // Every ID-stage term is masked by stall so a held ID instruction cannot redirect.
    assign w_jr         = ~bus.stall & bus.jr_ID;
    assign w_jump       = ~bus.stall & bus.jump_ID;
    assign w_mispredict = ~bus.stall & bus.branch_ID & (bus.taken_ID != r_pred_ID);
    assign w_redirect   = w_jr | w_jump | w_mispredict;
    assign w_resolve    = ~bus.stall & bus.branch_ID;

    always_comb begin
        w_sel = NPC_SEQ;
        if (w_jr) begin
            w_sel = NPC_JR;
        end else if (w_mispredict) begin
            w_sel = NPC_REC_ID;
        end else if (w_jump) begin
            w_sel = NPC_J_ID;
        end else if (w_pred_IF) begin
            w_sel = NPC_BR_IF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_pred_ID <= 1'b0;
            r_idx_ID  <= '0;
        end else if (!bus.stall) begin
            r_pc      <= bus.next_pc;
            // A prediction fetched under a redirect is squashed, so it must not be judged in ID.
            r_pred_ID <= w_pred_IF & ~w_redirect;
            r_idx_ID  <= w_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_br_cnt <= '0;
            r_mp_cnt <= '0;
        end else if (w_resolve) begin
            r_br_cnt <= r_br_cnt + 32'd1;
            r_mp_cnt <= r_mp_cnt + {31'd0, w_mispredict};
        end
    end

    assign bus.next_pc_sel = w_sel;
    assign bus.pc          = r_pc;
    assign bus.flush_IF    = w_redirect;
    assign bus.mispredict  = w_mispredict;
    assign bus.br_cnt      = r_br_cnt;
    assign bus.mp_cnt      = r_mp_cnt;

endmodule
